// File: rtl/mdu_issue_ctrl_if.sv
// mdu_issue_ctrl_if
//  Groups the decode/execute/MDU signals seen by the MDU issue controller.
//  master : pipeline side, drives instruction info and the MDU Busy flag
//  slave  : the issue controller, returns stall/flush controls and debug status
//  Signals:
//   IntExcReq  interrupt/exception request (MDU freezes while high)
//   D_Valid    D stage holds a real instruction
//   D_MDUOp    MDU opcode of the D instruction (5 bits)
//   E_Valid    E stage holds a real instruction
//   E_MDUOp    MDU opcode presented to the MDU this cycle (5 bits)
//   Busy       MDU busy flag
//   StallF     hold PC
//   StallD     hold F/D register
//   FlushE     insert bubble into D/E register
//   ProtErr    sticky Busy/shadow disagreement flag
//   StallCnt   saturating count of StallD cycles (32 bits)
interface mdu_issue_ctrl_if;
   logic        IntExcReq;
   logic        D_Valid;
   logic [4:0]  D_MDUOp;
   logic        E_Valid;
   logic [4:0]  E_MDUOp;
   logic        Busy;
   logic        StallF;
   logic        StallD;
   logic        FlushE;
   logic        ProtErr;
   logic [31:0] StallCnt;

   modport master (
      output IntExcReq, D_Valid, D_MDUOp, E_Valid, E_MDUOp, Busy,
      input  StallF, StallD, FlushE, ProtErr, StallCnt
   );

   modport slave (
      input  IntExcReq, D_Valid, D_MDUOp, E_Valid, E_MDUOp, Busy,
      output StallF, StallD, FlushE, ProtErr, StallCnt
   );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl
//  Decode-stage issue/stall controller sitting directly upstream of the MDU.
//  Holds MDU-class instructions in D while the MDU is busy or while a
//  multi-cycle op is entering it from E, tracks the expected busy window with
//  a shadow countdown, flags disagreement with the MDU Busy output, and counts
//  stall cycles.
//  Ports:
//   clk    clock, all state updates on posedge
//   reset  synchronous, active-high
//   bus    mdu_issue_ctrl_if.slave (see interface header for signal list)
//  Opcode encoding (mirrors settings.v): None=0, Mult=1, Multu=2, Div=3,
//  Divu=4, Mfhi=5, Mflo=6, Mthi=7, Mtlo=8, Msub=9; anything else is non-MDU.
module mdu_issue_ctrl #(
   parameter int MUL_TIME = 5,
   parameter int DIV_TIME = 10,
   parameter int CNT_W    = 4
) (
   input logic             clk,
   input logic             reset,
   mdu_issue_ctrl_if.slave bus
);

   localparam logic [4:0] MDU_MULT  = 5'd1;
   localparam logic [4:0] MDU_MULTU = 5'd2;
   localparam logic [4:0] MDU_DIV   = 5'd3;
   localparam logic [4:0] MDU_DIVU  = 5'd4;
   localparam logic [4:0] MDU_MFHI  = 5'd5;
   localparam logic [4:0] MDU_MFLO  = 5'd6;
   localparam logic [4:0] MDU_MTHI  = 5'd7;
   localparam logic [4:0] MDU_MTLO  = 5'd8;
   localparam logic [4:0] MDU_MSUB  = 5'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      ERR  = 2'd2
   } state_t;

   state_t             state;
   state_t             stateNext;
   logic [CNT_W-1:0]   shadow;
   logic               shadowNz;
   logic               afterReset;
   logic               dIsMd;
   logic               eMul;
   logic               eDiv;
   logic               eStart;
   logic               stall;
   logic               mismatch;
   logic [31:0]        stallCnt;

   // Instruction classification and the issue condition. An op only really
   // enters the MDU when it is not frozen by an interrupt and the previous
   // multi-cycle op has drained.
   always_comb begin
      dIsMd = bus.D_Valid &&
              (bus.D_MDUOp inside {MDU_MULT, MDU_MULTU, MDU_MSUB, MDU_DIV, MDU_DIVU,
                                   MDU_MFHI, MDU_MFLO, MDU_MTHI, MDU_MTLO});
      eMul     = bus.E_Valid && (bus.E_MDUOp inside {MDU_MULT, MDU_MULTU, MDU_MSUB});
      eDiv     = bus.E_Valid && (bus.E_MDUOp inside {MDU_DIV, MDU_DIVU});
      shadowNz = (shadow != '0);
      eStart   = (eMul || eDiv) && !bus.IntExcReq && !shadowNz;
      stall    = dIsMd && (bus.Busy || eStart || shadowNz);
      mismatch = !afterReset && (bus.Busy != shadowNz);
   end

   // Stall controls are purely combinational so the hold takes effect in the
   // same cycle the hazard appears.
   assign bus.StallD   = stall;
   assign bus.StallF   = stall;
   assign bus.FlushE   = stall;
   assign bus.ProtErr  = (state == ERR);
   assign bus.StallCnt = stallCnt;

   // Shadow countdown: freezes with the MDU during an interrupt request,
   // otherwise drains to zero and only reloads once it has drained.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow <= '0;
      end else if (bus.IntExcReq) begin
         shadow <= shadow;
      end else if (shadowNz) begin
         shadow <= shadow - 1'b1;
      end else if (eStart) begin
         shadow <= eMul ? CNT_W'(MUL_TIME) : CNT_W'(DIV_TIME);
      end
   end

   // The MDU comes out of reset in the same cycle as this block, so the first
   // cycle after reset is excluded from the Busy comparison.
   always_ff @(posedge clk) begin
      if (reset) begin
         afterReset <= 1'b1;
      end else begin
         afterReset <= 1'b0;
      end
   end

   // Debug state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Debug FSM next state: ERR is sticky and takes priority over everything
   // else, while stall logic keeps working independently.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE: if (eStart) stateNext = RUN;
         RUN:  if (!bus.IntExcReq && (shadow == CNT_W'(1))) stateNext = IDLE;
         ERR:  stateNext = ERR;
         default: stateNext = IDLE;
      endcase
      if (mismatch) begin
         stateNext = ERR;
      end
   end

   // Saturating stall-cycle counter for performance debug.
   always_ff @(posedge clk) begin
      if (reset) begin
         stallCnt <= '0;
      end else if (stall && (stallCnt != 32'hFFFF_FFFF)) begin
         stallCnt <= stallCnt + 32'd1;
      end
   end

endmodule
